// File: rtl/l2_cache_lock_ctrl_pkg.sv
// Shared types and constants for the L2 lock sequencer and its shadow lock storage.
package l2_cache_lock_ctrl_pkg;

    typedef enum logic [1:0] {
        STATUS_OK          = 2'd0,
        STATUS_REDUNDANT   = 2'd1,
        STATUS_REJECT_FULL = 2'd2
    } l2_lock_status_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_UPDATE
    } l2_lock_state_t;

    localparam int L2_LOCK_PERF_EVENTS = 3;

    // A single set or way still needs a one-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_cache_lock_ctrl_shadow.sv
// l2_lock_shadow: NUM_SETS x NUM_WAYS lock-bit mirror with synchronous clear, one read and one write port.
module l2_lock_shadow #(
    parameter int NUM_SETS = 1,
    parameter int NUM_WAYS = 4,
    parameter int SET_W    = 1,
    parameter int WAY_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SET_W-1:0]    rd_set,
    output logic [NUM_WAYS-1:0] rd_mask,
    input  logic                wr_en,
    input  logic [SET_W-1:0]    wr_set,
    input  logic [WAY_W-1:0]    wr_way,
    input  logic                wr_value
);

    logic [NUM_WAYS-1:0] mask [NUM_SETS];

    function automatic logic [NUM_WAYS-1:0] idx_to_oh(input logic [WAY_W-1:0] idx);
        logic [NUM_WAYS-1:0] oh;
        oh = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            oh[w] = (idx == WAY_W'(w));
        end
        return oh;
    endfunction

    always_comb begin
        rd_mask = '0;
        for (int s = 0; s < NUM_SETS; s++) begin
            if (rd_set == SET_W'(s)) rd_mask = mask[s];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) mask[s] <= '0;
        end else if (wr_en) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                if (wr_set == SET_W'(s)) begin
                    mask[s] <= (mask[s] & ~idx_to_oh(wr_way)) |
                               (wr_value ? idx_to_oh(wr_way) : '0);
                end
            end
        end
    end

endmodule

// File: rtl/l2_cache_lock_ctrl.sv
// Lock/unlock sequencer for the L2 LRU port: check shadow, issue access+lock, then update.
// Optional macro L2_LOCK_PERF_EN enables the perf_events pulses; otherwise perf_events is 0.
module l2_cache_lock_ctrl
    import l2_cache_lock_ctrl_pkg::*;
#(
    parameter int NUM_SETS        = 1,
    parameter int NUM_WAYS        = 4,
    parameter int SET_INDEX_WIDTH = idx_width(NUM_SETS),
    parameter int WAY_INDEX_WIDTH = idx_width(NUM_WAYS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [SET_INDEX_WIDTH-1:0]     req_set,
    input  logic [WAY_INDEX_WIDTH-1:0]     req_way,
    input  logic                           req_lock,
    output logic                           resp_valid,
    output l2_lock_status_t                resp_status,
    input  logic                           port_busy,
    output logic                           lru_access_en,
    output logic [SET_INDEX_WIDTH-1:0]     lru_access_set,
    output logic                           lru_lock_en,
    output logic                           lru_lock_value,
    output logic                           lru_update_en,
    output logic [WAY_INDEX_WIDTH-1:0]     lru_update_way,
    output logic [L2_LOCK_PERF_EVENTS-1:0] perf_events
);

    l2_lock_state_t               state;
    logic [SET_INDEX_WIDTH-1:0]   cmd_set;
    logic [WAY_INDEX_WIDTH-1:0]   cmd_way;
    logic                         cmd_lock;
    logic [NUM_WAYS-1:0]          shadow_mask;
    logic                         way_bit;
    int                           locked_cnt;
    logic                         is_redundant;
    logic                         is_full;
    logic                         issue_fire;

    l2_lock_shadow #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS),
        .SET_W    (SET_INDEX_WIDTH),
        .WAY_W    (WAY_INDEX_WIDTH)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .rd_set   (cmd_set),
        .rd_mask  (shadow_mask),
        .wr_en    (state == ST_UPDATE),
        .wr_set   (cmd_set),
        .wr_way   (cmd_way),
        .wr_value (cmd_lock)
    );

    always_comb begin
        way_bit    = 1'b0;
        locked_cnt = 0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (cmd_way == WAY_INDEX_WIDTH'(w)) way_bit = shadow_mask[w];
            locked_cnt = locked_cnt + int'(shadow_mask[w]);
        end
    end

    // Locking the last free way would leave the set with no replacement victim.
    assign is_redundant = (cmd_lock == way_bit);
    assign is_full      = cmd_lock && (locked_cnt == NUM_WAYS - 1);
    assign issue_fire   = (state == ST_ISSUE) && !port_busy;

    assign req_ready      = (state == ST_IDLE) && !reset;
    assign lru_access_en  = issue_fire;
    assign lru_lock_en    = issue_fire;
    assign lru_access_set = issue_fire ? cmd_set : '0;
    assign lru_lock_value = issue_fire && cmd_lock;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cmd_set        <= '0;
            cmd_way        <= '0;
            cmd_lock       <= 1'b0;
            resp_valid     <= 1'b0;
            resp_status    <= STATUS_OK;
            lru_update_en  <= 1'b0;
            lru_update_way <= '0;
        end else begin
            resp_valid     <= 1'b0;
            lru_update_en  <= 1'b0;
            lru_update_way <= '0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cmd_set  <= req_set;
                        cmd_way  <= req_way;
                        cmd_lock <= req_lock;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (is_redundant) begin
                        resp_valid  <= 1'b1;
                        resp_status <= STATUS_REDUNDANT;
                        state       <= ST_IDLE;
                    end else if (is_full) begin
                        resp_valid  <= 1'b1;
                        resp_status <= STATUS_REJECT_FULL;
                        state       <= ST_IDLE;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The OK response is raised with the update so it lands in the UPDATE cycle.
                    if (!port_busy) begin
                        lru_update_en  <= 1'b1;
                        lru_update_way <= cmd_way;
                        resp_valid     <= 1'b1;
                        resp_status    <= STATUS_OK;
                        state          <= ST_UPDATE;
                    end
                end
                ST_UPDATE: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

`ifdef L2_LOCK_PERF_EN
    logic [L2_LOCK_PERF_EVENTS-1:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= '0;
            if (state == ST_CHECK) begin
                if (is_redundant)  perf_q <= 3'b010;
                else if (is_full)  perf_q <= 3'b100;
            end else if (issue_fire) begin
                perf_q <= 3'b001;
            end
        end
    end

    assign perf_events = perf_q;
`else
    assign perf_events = '0;
`endif

endmodule

// File: tb/tb_l2_cache_lock_ctrl.sv
// Directed bench for l2_cache_lock_ctrl (8 sets x 4 ways).
module tb_l2_cache_lock_ctrl;
    import l2_cache_lock_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_set = '0;
    logic [1:0]      req_way = '0;
    logic            req_lock = 1'b0;
    logic            resp_valid;
    l2_lock_status_t resp_status;
    logic            port_busy = 1'b0;
    logic            lru_access_en;
    logic [2:0]      lru_access_set;
    logic            lru_lock_en;
    logic            lru_lock_value;
    logic            lru_update_en;
    logic [1:0]      lru_update_way;
    logic [2:0]      perf_events;

    int tests_run = 0;
    int tests_failed = 0;

    l2_cache_lock_ctrl #(.NUM_SETS(8), .NUM_WAYS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_set        (req_set),
        .req_way        (req_way),
        .req_lock       (req_lock),
        .resp_valid     (resp_valid),
        .resp_status    (resp_status),
        .port_busy      (port_busy),
        .lru_access_en  (lru_access_en),
        .lru_access_set (lru_access_set),
        .lru_lock_en    (lru_lock_en),
        .lru_lock_value (lru_lock_value),
        .lru_update_en  (lru_update_en),
        .lru_update_way (lru_update_way),
        .perf_events    (perf_events)
    );

    always #5 clk = ~clk;

    // Result of one command; cycles are counted from the handshake edge (cycle 0 = handshake cycle).
    bit              r_got;
    int              r_resp_cyc, r_acc_cyc, r_upd_cyc, r_hs_wait;
    l2_lock_status_t r_status;
    bit              r_fields_ok, r_lru_seen, r_violation;
    logic [2:0]      r_perf;

    task automatic run_cmd(input logic [2:0] set, input logic [1:0] way, input logic lock,
                           input int busy_n);
        r_got = 0; r_resp_cyc = -1; r_acc_cyc = -1; r_upd_cyc = -1; r_hs_wait = 0;
        r_status = STATUS_OK; r_fields_ok = 1; r_lru_seen = 0; r_violation = 0; r_perf = '0;
        req_set = set; req_way = way; req_lock = lock; req_valid = 1'b1;
        while (!req_ready && r_hs_wait < 10) begin
            @(negedge clk); #1;
            r_hs_wait++;
        end
        @(posedge clk);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            port_busy = (c >= 2 && c < 2 + busy_n);
            #1;
            if (lru_access_en || lru_lock_en || lru_update_en) r_lru_seen = 1;
            if (lru_lock_en && port_busy) r_violation = 1;
            if (lru_access_en !== lru_lock_en) r_fields_ok = 0;
            if (lru_access_en) begin
                r_acc_cyc = c;
                if (lru_access_set !== set || lru_lock_value !== lock) r_fields_ok = 0;
            end
            if (lru_update_en) begin
                r_upd_cyc = c;
                if (lru_update_way !== way) r_fields_ok = 0;
            end
            if (resp_valid) begin
                r_got = 1; r_resp_cyc = c; r_status = resp_status; r_perf = perf_events;
                break;
            end
        end
        port_busy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({req_ready, resp_valid, lru_access_en, lru_lock_en, lru_update_en, lru_lock_value} !== 6'b0 ||
            lru_access_set !== 3'd0 || lru_update_way !== 2'd0 || perf_events !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b resp=%b acc=%b lock=%b upd=%b perf=%b, required all 0",
                     req_ready, resp_valid, lru_access_en, lru_lock_en, lru_update_en, perf_events);
        end
        reset = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_lock_ok();
        run_cmd(3'd3, 2'd1, 1'b1, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_OK || r_resp_cyc != 3) begin
            tests_failed++;
            $display("FAIL lock_ok_resp: got=%0d status=%0d cyc=%0d, required 1/0/3", r_got, r_status, r_resp_cyc);
        end
        tests_run++;
        if (r_acc_cyc != 2 || r_upd_cyc != 3) begin
            tests_failed++;
            $display("FAIL lock_ok_timing: acc_cyc=%0d upd_cyc=%0d, required 2/3", r_acc_cyc, r_upd_cyc);
        end
        tests_run++;
        if (!r_fields_ok) begin
            tests_failed++;
            $display("FAIL lock_ok_fields: set/value/way wrong, required set=3 value=1 way=1");
        end
    endtask

    task automatic test_redundant();
        run_cmd(3'd3, 2'd1, 1'b1, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_REDUNDANT || r_resp_cyc != 2 || r_lru_seen) begin
            tests_failed++;
            $display("FAIL redundant_lock: got=%0d status=%0d cyc=%0d lru=%0d, required 1/1/2/0",
                     r_got, r_status, r_resp_cyc, r_lru_seen);
        end
        run_cmd(3'd3, 2'd2, 1'b0, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_REDUNDANT || r_resp_cyc != 2 || r_lru_seen) begin
            tests_failed++;
            $display("FAIL redundant_unlock: got=%0d status=%0d cyc=%0d lru=%0d, required 1/1/2/0",
                     r_got, r_status, r_resp_cyc, r_lru_seen);
        end
    endtask

    task automatic test_reject_full();
        for (int w = 0; w < 3; w++) begin
            run_cmd(3'd5, 2'(w), 1'b1, 0);
            tests_run++;
            if (!r_got || r_status !== STATUS_OK || r_resp_cyc != 3) begin
                tests_failed++;
                $display("FAIL fill_lock_way%0d: got=%0d status=%0d cyc=%0d, required 1/0/3",
                         w, r_got, r_status, r_resp_cyc);
            end
        end
        run_cmd(3'd5, 2'd3, 1'b1, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_REJECT_FULL || r_resp_cyc != 2 || r_lru_seen) begin
            tests_failed++;
            $display("FAIL reject_full: got=%0d status=%0d cyc=%0d lru=%0d, required 1/2/2/0",
                     r_got, r_status, r_resp_cyc, r_lru_seen);
        end
        run_cmd(3'd5, 2'd0, 1'b0, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_OK || !r_fields_ok) begin
            tests_failed++;
            $display("FAIL unlock_way0: got=%0d status=%0d fields=%0d, required 1/0/1", r_got, r_status, r_fields_ok);
        end
        run_cmd(3'd5, 2'd3, 1'b1, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_OK || r_resp_cyc != 3) begin
            tests_failed++;
            $display("FAIL lock_way3_after_unlock: got=%0d status=%0d cyc=%0d, required 1/0/3",
                     r_got, r_status, r_resp_cyc);
        end
    endtask

    task automatic test_stall();
        run_cmd(3'd6, 2'd2, 1'b1, 4);
        tests_run++;
        if (r_violation || r_acc_cyc != 6 || r_upd_cyc != 7) begin
            tests_failed++;
            $display("FAIL stall_issue: violation=%0d acc_cyc=%0d upd_cyc=%0d, required 0/6/7",
                     r_violation, r_acc_cyc, r_upd_cyc);
        end
        tests_run++;
        if (!r_got || r_status !== STATUS_OK || r_resp_cyc != 7 || !r_fields_ok) begin
            tests_failed++;
            $display("FAIL stall_resp: got=%0d status=%0d cyc=%0d fields=%0d, required 1/0/7/1",
                     r_got, r_status, r_resp_cyc, r_fields_ok);
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(3'd6, 2'd2, 1'b0, 0);
        run_cmd(3'd6, 2'd2, 1'b1, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_OK || r_hs_wait != 1) begin
            tests_failed++;
            $display("FAIL b2b_after_ok: got=%0d status=%0d wait=%0d, required 1/0/1", r_got, r_status, r_hs_wait);
        end
        run_cmd(3'd6, 2'd2, 1'b1, 0);
        run_cmd(3'd6, 2'd1, 1'b1, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_OK || r_hs_wait != 0) begin
            tests_failed++;
            $display("FAIL b2b_after_redundant: got=%0d status=%0d wait=%0d, required 1/0/0", r_got, r_status, r_hs_wait);
        end
    endtask

    task automatic test_reset_mid();
        int resp_seen;
        @(negedge clk); @(negedge clk);
        req_set = 3'd3; req_way = 2'd0; req_lock = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        port_busy = 1'b1;
        #1;
        tests_run++;
        if (lru_lock_en !== 1'b0 || lru_access_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_stalled: lock_en=%b access_en=%b, required 0/0", lru_lock_en, lru_access_en);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        tests_run++;
        if ({resp_valid, lru_access_en, lru_lock_en, lru_update_en, req_ready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: resp=%b acc=%b lock=%b upd=%b ready=%b, required all 0",
                     resp_valid, lru_access_en, lru_lock_en, lru_update_en, req_ready);
        end
        reset = 1'b0;
        port_busy = 1'b0;
        resp_seen = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (resp_valid || lru_access_en || lru_update_en) resp_seen++;
        end
        tests_run++;
        if (resp_seen != 0) begin
            tests_failed++;
            $display("FAIL mid_reset_no_resp: activity cycles=%0d, required 0", resp_seen);
        end
        run_cmd(3'd3, 2'd1, 1'b1, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_OK) begin
            tests_failed++;
            $display("FAIL shadow_cleared_s3: got=%0d status=%0d, required 1/0", r_got, r_status);
        end
        run_cmd(3'd5, 2'd3, 1'b1, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_OK) begin
            tests_failed++;
            $display("FAIL shadow_cleared_s5: got=%0d status=%0d, required 1/0", r_got, r_status);
        end
    endtask

    task automatic test_perf();
        logic [2:0] exp_ok, exp_red, exp_rej;
`ifdef L2_LOCK_PERF_EN
        exp_ok = 3'b001; exp_red = 3'b010; exp_rej = 3'b100;
`else
        exp_ok = 3'b000; exp_red = 3'b000; exp_rej = 3'b000;
`endif
        run_cmd(3'd1, 2'd0, 1'b1, 0);
        tests_run++;
        if (!r_got || r_perf !== exp_ok) begin
            tests_failed++;
            $display("FAIL perf_ok: got=%0d perf=%b, required %b", r_got, r_perf, exp_ok);
        end
        run_cmd(3'd1, 2'd0, 1'b1, 0);
        tests_run++;
        if (!r_got || r_perf !== exp_red) begin
            tests_failed++;
            $display("FAIL perf_redundant: got=%0d perf=%b, required %b", r_got, r_perf, exp_red);
        end
        run_cmd(3'd1, 2'd1, 1'b1, 0);
        run_cmd(3'd1, 2'd2, 1'b1, 0);
        run_cmd(3'd1, 2'd3, 1'b1, 0);
        tests_run++;
        if (!r_got || r_status !== STATUS_REJECT_FULL || r_perf !== exp_rej) begin
            tests_failed++;
            $display("FAIL perf_reject: got=%0d status=%0d perf=%b, required 1/2/%b", r_got, r_status, r_perf, exp_rej);
        end
        @(negedge clk); #1;
        tests_run++;
        if (perf_events !== 3'b000) begin
            tests_failed++;
            $display("FAIL perf_idle: perf=%b, required 000", perf_events);
        end
    endtask

    initial begin
        test_reset();
        test_lock_ok();
        test_redundant();
        test_reject_full();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
